// File: rtl/tone_scheduler.sv
`timescale 1ns / 1ps
// tone_scheduler
// Shares one square-wave tone path between three requesters (siren, key
// beep, alarm). A fixed-priority pick is made only while idle; the granted
// note then plays to completion (or until its requester lets go), followed
// by a silence gap. The audio pin carries the square wave gated down to
// 1-in-2^ATTN_BITS duty for volume control.
module tone_scheduler #(
    parameter int TICK_CYCLES = 100000,  // clocks per 1 ms tick
    parameter int GAP_MS      = 20,      // silence between notes, 0 = none
    parameter int ATTN_BITS   = 7        // volume gate width, 1..8
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [16:0] div0,
    input  logic [16:0] div1,
    input  logic [16:0] div2,
    input  logic [15:0] dur0,
    input  logic [15:0] dur1,
    input  logic [15:0] dur2,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        busy,
    output logic        speaker,
    output logic        audio
);

    // A 1-cycle tick still needs a 1-bit counter so the vector is legal.
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [15:0]   GAP_LEN   = 16'(GAP_MS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [16:0]   div_q, div_d;      // latched half-period of the owner
    logic [15:0]   dur_q, dur_d;      // latched note length in ms
    logic [16:0]   tone_q, tone_d;    // half-period down-counter
    logic [TW-1:0] tick_q, tick_d;    // clocks within the current ms
    logic [15:0]   ms_q, ms_d;        // whole ms elapsed in PLAY or GAP
    logic [2:0]    grant_q, grant_d;
    logic [2:0]    done_q, done_d;
    logic          speaker_q, speaker_d;
    logic          audio_q, audio_d;

    logic [1:0]    sel_idx;
    logic [16:0]   sel_div;
    logic [15:0]   sel_dur;
    logic          req_any;
    logic          tick_wrap;
    logic          owner_lost;
    logic          atten_open;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    assign req_any    = |req;
    assign tick_wrap  = (tick_q == TICK_LAST);
    // The owner abandons its note when its own request bit drops.
    assign owner_lost = ((req & grant_q) == 3'b000);
    // Volume gate: only one phase in every 2^ATTN_BITS lets the wave through.
    assign atten_open = (tone_q[ATTN_BITS-1:0] == '0);

    // Fixed-priority pick of the highest set request and its settings.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sel_idx = 2'd0;
        sel_div = div0;
        sel_dur = dur0;
        if (req[2]) begin
            sel_idx = 2'd2;
            sel_div = div2;
            sel_dur = dur2;
        end else if (req[1]) begin
            sel_idx = 2'd1;
            sel_div = div1;
            sel_dur = dur1;
        end
    end

    // Next-state and next-output logic for the IDLE/PLAY/GAP sequencer.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        dur_d     = dur_q;
        tone_d    = tone_q;
        tick_d    = tick_q;
        ms_d      = ms_q;
        grant_d   = grant_q;
        done_d    = 3'b000;
        speaker_d = speaker_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    div_d = sel_div;
                    dur_d = sel_dur;
                    if ((sel_div == 17'd0) || (sel_dur == 16'd0)) begin
                        // Nothing playable: acknowledge at once, stay idle.
                        done_d = onehot(sel_idx);
                    end else begin
                        state_d   = S_PLAY;
                        grant_d   = onehot(sel_idx);
                        tone_d    = sel_div - 17'd1;
                        tick_d    = '0;
                        ms_d      = 16'd0;
                        speaker_d = 1'b0;
                    end
                end
            end

            S_PLAY: begin
                // Half-period is exactly div clocks: count div-1 down to 0.
                if (tone_q == 17'd0) begin
                    tone_d    = div_q - 17'd1;
                    speaker_d = ~speaker_q;
                end else begin
                    tone_d = tone_q - 17'd1;
                end

                if (tick_wrap) begin
                    tick_d = '0;
                    ms_d   = ms_q + 16'd1;
                end else begin
                    tick_d = tick_q + TW'(1);
                end

                // Completion outranks abort when both land on the same cycle.
                if (tick_wrap && ((ms_q + 16'd1) == dur_q)) begin
                    done_d    = grant_q;
                    grant_d   = 3'b000;
                    speaker_d = 1'b0;
                    tone_d    = 17'd0;
                    tick_d    = '0;
                    ms_d      = 16'd0;
                    state_d   = (GAP_MS == 0) ? S_IDLE : S_GAP;
                end else if (owner_lost) begin
                    grant_d   = 3'b000;
                    speaker_d = 1'b0;
                    tone_d    = 17'd0;
                    tick_d    = '0;
                    ms_d      = 16'd0;
                    state_d   = (GAP_MS == 0) ? S_IDLE : S_GAP;
                end
            end

            S_GAP: begin
                if (tick_wrap) begin
                    tick_d = '0;
                    if ((ms_q + 16'd1) == GAP_LEN) begin
                        ms_d    = 16'd0;
                        state_d = S_IDLE;
                    end else begin
                        ms_d = ms_q + 16'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end

            default: begin
                state_d   = S_IDLE;
                grant_d   = 3'b000;
                speaker_d = 1'b0;
            end
        endcase

        // Audio trails speaker by one clock and is forced silent as soon as
        // the note ends, so GAP never carries a stray pulse.
        audio_d = speaker_q && atten_open && (state_d == S_PLAY);
    end

    // State and counter registers; async reset drops every output at once.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= 17'd0;
            dur_q     <= 16'd0;
            tone_q    <= 17'd0;
            tick_q    <= '0;
            ms_q      <= 16'd0;
            grant_q   <= 3'b000;
            done_q    <= 3'b000;
            speaker_q <= 1'b0;
            audio_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            div_q     <= div_d;
            dur_q     <= dur_d;
            tone_q    <= tone_d;
            tick_q    <= tick_d;
            ms_q      <= ms_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            speaker_q <= speaker_d;
            audio_q   <= audio_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign busy    = (state_q != S_IDLE);
    assign speaker = speaker_q;
    assign audio   = audio_q;

endmodule

// File: tb/tb_tone_scheduler.sv
`timescale 1ns / 1ps
// Bench for tone_scheduler: directed scenarios plus randomized notes, all
// judged against expectations computed arithmetically from the note rules
// (half-period, note length, gap length, volume gate).
module tb_tone_scheduler;

    localparam int TICK = 100;
    localparam int GAP  = 2;
    localparam int ATTN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [16:0] div0, div1, div2;
    logic [15:0] dur0, dur1, dur2;
    logic [2:0]  grant, done;
    logic        busy, speaker, audio;

    int tests = 0;
    int fails = 0;
    int last_pulses;

    tone_scheduler #(
        .TICK_CYCLES(TICK),
        .GAP_MS     (GAP),
        .ATTN_BITS  (ATTN)
    ) dut (
        .CLK100MHZ(clk),
        .rst      (rst),
        .req      (req),
        .div0     (div0),
        .div1     (div1),
        .div2     (div2),
        .dur0     (dur0),
        .dur1     (dur1),
        .dur2     (dur2),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .speaker  (speaker),
        .audio    (audio)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [2:0] oh(input int i);
        return 3'(1 << i);
    endfunction

    // Speaker level j clocks after grant: flips every div clocks, starts low.
    function automatic logic spk_at(input int dv, input int j);
        return ((j / dv) % 2) == 1;
    endfunction

    // Audio mirrors the previous clock: speaker high and the count of
    // clocks left in the half-period (div-1 down to 0) a multiple of 2^ATTN.
    function automatic logic aud_at(input int dv, input int j);
        int left;
        if (j == 0) return 1'b0;
        left = dv - 1 - ((j - 1) % dv);
        return spk_at(dv, j - 1) && ((left % (1 << ATTN)) == 0);
    endfunction

    task automatic set_cfg(input int idx, input int dv, input int du);
        case (idx)
            0: begin div0 = 17'(dv); dur0 = 16'(du); end
            1: begin div1 = 17'(dv); dur1 = 16'(du); end
            default: begin div2 = 17'(dv); dur2 = 16'(du); end
        endcase
    endtask

    // Plays one note for requester idx and follows it through the gap.
    // extra: other request bits held throughout; raise_bits are added at
    // clock raise_j; abort_j > 0 drops the owner's request at that clock.
    task automatic note(input int idx, input int dv, input int du,
                        input logic [2:0] extra, input int raise_j,
                        input logic [2:0] raise_bits, input int abort_j);
        int len;
        int end_j;
        bit aborted;
        int e_grant, e_done, e_busy, e_spk, e_aud;
        len     = du * TICK;
        aborted = (abort_j > 0) && (abort_j < len - 1);
        end_j   = aborted ? abort_j + 1 : len;
        e_grant = 0; e_done = 0; e_busy = 0; e_spk = 0; e_aud = 0;
        last_pulses = 0;

        set_cfg(idx, dv, du);
        req = oh(idx) | extra;
        step();
        check($sformatf("grant_start%0d", idx), 32'(grant), 32'(oh(idx)));
        check("busy_start", 32'(busy), 32'd1);
        check("speaker_start", 32'(speaker), 32'd0);

        for (int j = 1; j < end_j; j++) begin
            step();
            if (grant !== oh(idx)) e_grant++;
            if (done !== 3'b000) e_done++;
            if (busy !== 1'b1) e_busy++;
            if (speaker !== spk_at(dv, j)) e_spk++;
            if (audio !== aud_at(dv, j)) e_aud++;
            if ((j > dv) && (j <= 2 * dv) && (audio === 1'b1)) last_pulses++;
            if (j == raise_j) req = req | raise_bits;
            if (j == abort_j) req = req & ~oh(idx);
        end
        check("play_grant_errs", e_grant, 0);
        check("play_done_errs", e_done, 0);
        check("play_busy_errs", e_busy, 0);
        check("play_speaker_errs", e_spk, 0);
        check("play_audio_errs", e_aud, 0);

        step();
        if (aborted) begin
            check("abort_done", 32'(done), 32'd0);
        end else begin
            check($sformatf("done_pulse%0d", idx), 32'(done), 32'(oh(idx)));
        end
        check("end_grant", 32'(grant), 32'd0);
        check("end_speaker", 32'(speaker), 32'd0);
        check("end_audio", 32'(audio), 32'd0);
        check("end_busy", 32'(busy), 32'd1);
        req = req & ~oh(idx);

        e_grant = 0; e_done = 0; e_busy = 0; e_spk = 0;
        for (int g = 1; g <= GAP * TICK; g++) begin
            step();
            if (grant !== 3'b000) e_grant++;
            if (done !== 3'b000) e_done++;
            if (busy !== (g < GAP * TICK)) e_busy++;
            if ((speaker !== 1'b0) || (audio !== 1'b0)) e_spk++;
        end
        check("gap_grant_errs", e_grant, 0);
        check("gap_done_errs", e_done, 0);
        check("gap_busy_errs", e_busy, 0);
        check("gap_silent_errs", e_spk, 0);
    endtask

    initial begin
        int idx, dv, du, ab;
        rst = 1'b1;
        req = 3'b000;
        div0 = '0; div1 = '0; div2 = '0;
        dur0 = '0; dur1 = '0; dur2 = '0;
        step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_speaker", 32'(speaker), 32'd0);
        check("rst_audio", 32'(audio), 32'd0);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Single note on the lowest-priority requester.
        note(0, 10, 5, 3'b000, 0, 3'b000, 0);

        // Simultaneous requests: bit 2 wins, bit 0 follows after the gap.
        set_cfg(0, 9, 2);
        note(2, 12, 2, 3'b001, 0, 3'b000, 0);
        note(0, 9, 2, 3'b000, 0, 3'b000, 0);

        // No preemption: bit 2 rises mid-note and waits for the gap.
        set_cfg(2, 6, 1);
        note(0, 10, 5, 3'b000, 100, 3'b100, 0);
        note(2, 6, 1, 3'b000, 0, 3'b000, 0);

        // Abort 50 clocks in, then a drop on the final clock (done wins).
        note(0, 10, 5, 3'b000, 0, 3'b000, 50);
        note(1, 5, 1, 3'b000, 0, 3'b000, TICK - 1);

        // Degenerate settings: immediate done, never granted.
        set_cfg(1, 0, 5);
        req = 3'b010;
        step();
        check("degen_div_done", 32'(done), 32'b010);
        check("degen_div_grant", 32'(grant), 32'd0);
        check("degen_div_busy", 32'(busy), 32'd0);
        req = 3'b000;
        step();
        check("degen_div_done_clear", 32'(done), 32'd0);
        check("degen_div_busy2", 32'(busy), 32'd0);
        set_cfg(1, 10, 0);
        req = 3'b010;
        step();
        check("degen_dur_done", 32'(done), 32'b010);
        check("degen_dur_grant", 32'(grant), 32'd0);
        check("degen_dur_busy", 32'(busy), 32'd0);
        req = 3'b000;
        step();
        check("degen_dur_busy2", 32'(busy), 32'd0);

        // Attenuation: div 16 with 3 gate bits gives 2 pulses per high half.
        note(0, 16, 2, 3'b000, 0, 3'b000, 0);
        check("atten_pulses", last_pulses, 2);

        // Randomized notes, some aborted at a random clock.
        for (int k = 0; k < 8; k++) begin
            idx = int'($urandom_range(0, 2));
            dv  = int'($urandom_range(1, 40));
            du  = int'($urandom_range(1, 3));
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, du * TICK - 1)) : 0;
            note(idx, dv, du, 3'b000, 0, 3'b000, ab);
        end

        // Reset in the middle of a note clears everything asynchronously.
        set_cfg(0, 16, 3);
        req = 3'b001;
        step();
        check("pre_rst_grant", 32'(grant), 32'b001);
        repeat (40) step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_speaker", 32'(speaker), 32'd0);
        check("async_rst_audio", 32'(audio), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        req = 3'b000;
        step();
        rst = 1'b0;
        step();
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
